framebuffer_write_scheduler: RTL

- Shares the single framebuffer write master between two requesters: the rasteriser pixel stream and an internal clear/fill engine.
- Clips each pixel to the screen, converts (x,y) to a byte address, and issues one 32-bit write per pixel, honouring back-pressure on both sides.
- Sits between the rasteriser pixel output (pixel_data, pixel_data_valid, pixel_fifo_full) and the SDRAM/framebuffer memory-mapped write port.

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/fb_address_gen.sv | 24 ++
 rtl/framebuffer_write_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants for the framebuffer write path: state encoding, pixel field layout, widths.
package gpu_pkg;

   localparam int unsigned STATE_W = 1;
   localparam logic [STATE_W-1:0] STATE_IDLE  = 1'b0;
   localparam logic [STATE_W-1:0] STATE_CLEAR = 1'b1;

   localparam int unsigned PIX_X_MSB   = 63;
   localparam int unsigned PIX_X_LSB   = 48;
   localparam int unsigned PIX_Y_MSB   = 47;
   localparam int unsigned PIX_Y_LSB   = 32;
   localparam int unsigned PIX_COL_MSB = 31;

   localparam int unsigned COORD_W = 16;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 16;

   // Saturating increment for the clipped-pixel counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/fb_address_gen.sv
// Screen clip test and (x,y) -> framebuffer byte address, all 32-bit wrapping arithmetic.
module fb_address_gen
   import gpu_pkg::*;
#(
   parameter int unsigned WIDTH   = 640,
   parameter int unsigned HEIGHT  = 480,
   parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  address_c,
   output logic               in_bounds_c
);

   logic [ADDR_W-1:0] pix_index;

   // Linear pixel index, byte address and unsigned bounds check.
   always_comb begin
      pix_index   = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
      address_c   = FB_BASE + (pix_index << 2);
      in_bounds_c = (ADDR_W'(x) < ADDR_W'(WIDTH)) && (ADDR_W'(y) < ADDR_W'(HEIGHT));
   end

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Arbitrates the framebuffer write master between the rasteriser pixel stream and the clear engine.
module framebuffer_write_scheduler
   import gpu_pkg::*;
#(
   parameter int unsigned WIDTH   = 640,
   parameter int unsigned HEIGHT  = 480,
   parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [63:0]       pixel_data,
   input  logic              pixel_data_valid,
   output logic              pixel_fifo_full,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_colour,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] avm_address,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_write,
   input  logic              avm_waitrequest,
   output logic [CNT_W-1:0]  dropped_count
);

   localparam int unsigned       FILL_COUNT = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(FILL_COUNT - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic               clear_pending_q, clear_pending_d;
   logic               avm_write_q, avm_write_d;
   logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
   logic [DATA_W-1:0]  avm_writedata_q, avm_writedata_d;
   logic               clear_busy_q, clear_busy_d;
   logic               clear_done_q, clear_done_d;
   logic [CNT_W-1:0]   dropped_count_q, dropped_count_d;
   logic [ADDR_W-1:0]  fill_idx_q, fill_idx_d;
   logic [DATA_W-1:0]  fill_colour_q, fill_colour_d;

   logic [ADDR_W-1:0]  pix_addr;
   logic               pix_in_bounds;
   logic               beat_done;
   logic               stalled;
   logic               pix_accept;
   logic               clear_accept;
   logic [ADDR_W-1:0]  fill_next;

   fb_address_gen #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .FB_BASE (FB_BASE)
   ) u_addr (
      .x           (pixel_data[PIX_X_MSB:PIX_X_LSB]),
      .y           (pixel_data[PIX_Y_MSB:PIX_Y_LSB]),
      .address_c   (pix_addr),
      .in_bounds_c (pix_in_bounds)
   );

   // Back-pressure to the rasteriser; a pending or starting clear blocks pixels too.
   assign pixel_fifo_full = (avm_write_q && avm_waitrequest) || (state_q == STATE_CLEAR)
                          || clear_pending_q || clear_start;

   assign avm_write     = avm_write_q;
   assign avm_address   = avm_address_q;
   assign avm_writedata = avm_writedata_q;
   assign clear_busy    = clear_busy_q;
   assign clear_done    = clear_done_q;
   assign dropped_count = dropped_count_q;

   // Next-state, fill sweep and write beat scheduling.
   always_comb begin
      state_d         = state_q;
      clear_pending_d = clear_pending_q;
      avm_write_d     = avm_write_q;
      avm_address_d   = avm_address_q;
      avm_writedata_d = avm_writedata_q;
      clear_busy_d    = clear_busy_q;
      clear_done_d    = 1'b0;
      dropped_count_d = dropped_count_q;
      fill_idx_d      = fill_idx_q;
      fill_colour_d   = fill_colour_q;

      beat_done    = avm_write_q && !avm_waitrequest;
      stalled      = avm_write_q && avm_waitrequest;
      pix_accept   = pixel_data_valid && !pixel_fifo_full;
      clear_accept = clear_start && (state_q == STATE_IDLE) && !clear_pending_q;
      fill_next    = fill_idx_q + ADDR_W'(1);

      if (beat_done) avm_write_d = 1'b0;

      if (state_q == STATE_IDLE) begin
         if (clear_accept) begin
            clear_busy_d  = 1'b1;
            fill_colour_d = clear_colour;
            if (stalled) begin
               clear_pending_d = 1'b1;
            end else begin
               state_d         = STATE_CLEAR;
               fill_idx_d      = '0;
               avm_write_d     = 1'b1;
               avm_address_d   = FB_BASE;
               avm_writedata_d = clear_colour;
            end
         end else if (clear_pending_q) begin
            if (beat_done) begin
               clear_pending_d = 1'b0;
               state_d         = STATE_CLEAR;
               fill_idx_d      = '0;
               avm_write_d     = 1'b1;
               avm_address_d   = FB_BASE;
               avm_writedata_d = fill_colour_q;
            end
         end else if (pix_accept) begin
            if (pix_in_bounds) begin
               avm_write_d     = 1'b1;
               avm_address_d   = pix_addr;
               avm_writedata_d = pixel_data[PIX_COL_MSB:0];
            end else begin
               dropped_count_d = sat_inc(dropped_count_q);
            end
         end
      end else begin
         if (beat_done) begin
            if (fill_idx_q == FILL_LAST) begin
               state_d      = STATE_IDLE;
               clear_busy_d = 1'b0;
               clear_done_d = 1'b1;
            end else begin
               fill_idx_d      = fill_next;
               avm_write_d     = 1'b1;
               avm_address_d   = FB_BASE + (fill_next << 2);
               avm_writedata_d = fill_colour_q;
            end
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q         <= STATE_IDLE;
         clear_pending_q <= 1'b0;
         avm_write_q     <= 1'b0;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
         clear_busy_q    <= 1'b0;
         clear_done_q    <= 1'b0;
         dropped_count_q <= '0;
         fill_idx_q      <= '0;
         fill_colour_q   <= '0;
      end else begin
         state_q         <= state_d;
         clear_pending_q <= clear_pending_d;
         avm_write_q     <= avm_write_d;
         avm_address_q   <= avm_address_d;
         avm_writedata_q <= avm_writedata_d;
         clear_busy_q    <= clear_busy_d;
         clear_done_q    <= clear_done_d;
         dropped_count_q <= dropped_count_d;
         fill_idx_q      <= fill_idx_d;
         fill_colour_q   <= fill_colour_d;
      end
   end

endmodule
